display_scheduler: RTL and testbench

DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

---
 rtl/display_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_display_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : display_scheduler
//  Description : Picks which candidate count drives a two-digit 7-segment
//                display. In SCAN it rotates automatically or steps on a
//                button. On a result request it snapshots all four counts,
//                finds the maximum one candidate per cycle (CALC), and holds
//                the winner on the display (RESULT) until "next" is pressed.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                cnt0..cnt3 [6:0]    - candidate vote counts
//                next_btn            - level, rising edge = step / leave result
//                auto_en             - level, 1 = auto-rotate in SCAN
//                result_req          - level, rising edge = compute winner
//                disp_n [6:0]        - value for the 2-digit decoder
//                disp_sel [1:0]      - candidate index being shown
//                led [3:0]           - one-hot of disp_sel
//                busy                - winner comparison in progress
//                result_valid        - winner result on display
//                tie                 - maximum shared by several candidates
//  Revision    : 1.0 - initial release
// ============================================================================
module display_scheduler #(
    parameter int DWELL = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] cnt0,
    input  logic [6:0] cnt1,
    input  logic [6:0] cnt2,
    input  logic [6:0] cnt3,
    input  logic       next_btn,
    input  logic       auto_en,
    input  logic       result_req,
    output logic [6:0] disp_n,
    output logic [1:0] disp_sel,
    output logic [3:0] led,
    output logic       busy,
    output logic       result_valid,
    output logic       tie
);

    localparam logic [1:0]  c_ST_SCAN   = 2'd0;
    localparam logic [1:0]  c_ST_CALC   = 2'd1;
    localparam logic [1:0]  c_ST_RESULT = 2'd2;
    // DWELL may be as large as 2^26, so its last count fits in 26 bits.
    localparam logic [25:0] c_DWELL_LAST = 26'(DWELL - 1);

    logic [1:0]  r_state;
    logic [25:0] r_dwell;
    logic        r_next_prev;
    logic        r_req_prev;
    logic [6:0]  r_snap [4];
    logic [6:0]  r_best;
    logic [1:0]  r_best_idx;
    logic        r_tie_acc;
    logic [1:0]  r_idx;

    logic        w_next_edge;
    logic        w_req_edge;
    logic [6:0]  w_cnt_sel;
    logic [1:0]  w_sel_inc;
    logic [6:0]  w_cand;
    logic        w_gt;
    logic        w_eq;
    logic [6:0]  w_best_nxt;
    logic [1:0]  w_bidx_nxt;
    logic        w_tie_nxt;

    function automatic logic [3:0] onehot(input logic [1:0] s);
        return 4'b0001 << s;
    endfunction

    assign w_next_edge = next_btn & ~r_next_prev;
    assign w_req_edge  = result_req & ~r_req_prev;
    assign w_sel_inc   = disp_sel + 2'd1;

    always_comb begin
        w_cnt_sel = cnt0;
        case (disp_sel)
            2'd0:    w_cnt_sel = cnt0;
            2'd1:    w_cnt_sel = cnt1;
            2'd2:    w_cnt_sel = cnt2;
            default: w_cnt_sel = cnt3;
        endcase
    end

    // One comparison step of the running maximum. The final step's result
    // is also what lands on the outputs when entering RESULT.
    always_comb begin
        w_cand     = r_snap[r_idx];
        w_gt       = (w_cand > r_best);
        w_eq       = (w_cand == r_best);
        w_best_nxt = w_gt ? w_cand : r_best;
        w_bidx_nxt = w_gt ? r_idx : r_best_idx;
        w_tie_nxt  = w_gt ? 1'b0 : (w_eq ? 1'b1 : r_tie_acc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_SCAN;
            r_dwell      <= '0;
            // Preset high so a level held through reset is not seen as an edge.
            r_next_prev  <= 1'b1;
            r_req_prev   <= 1'b1;
            r_snap[0]    <= '0;
            r_snap[1]    <= '0;
            r_snap[2]    <= '0;
            r_snap[3]    <= '0;
            r_best       <= '0;
            r_best_idx   <= '0;
            r_tie_acc    <= 1'b0;
            r_idx        <= '0;
            disp_n       <= '0;
            disp_sel     <= '0;
            led          <= 4'b0001;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            tie          <= 1'b0;
        end else begin
            r_next_prev <= next_btn;
            r_req_prev  <= result_req;
            case (r_state)
                c_ST_SCAN: begin
                    disp_n <= w_cnt_sel;
                    if (w_req_edge) begin
                        r_snap[0]  <= cnt0;
                        r_snap[1]  <= cnt1;
                        r_snap[2]  <= cnt2;
                        r_snap[3]  <= cnt3;
                        r_best     <= cnt0;
                        r_best_idx <= 2'd0;
                        r_tie_acc  <= 1'b0;
                        r_idx      <= 2'd1;
                        r_dwell    <= '0;
                        busy       <= 1'b1;
                        r_state    <= c_ST_CALC;
                    end else if (w_next_edge) begin
                        // Also covers a coincident dwell expiry: one step only.
                        disp_sel <= w_sel_inc;
                        led      <= onehot(w_sel_inc);
                        r_dwell  <= '0;
                    end else if (auto_en) begin
                        if (r_dwell == c_DWELL_LAST) begin
                            r_dwell  <= '0;
                            disp_sel <= w_sel_inc;
                            led      <= onehot(w_sel_inc);
                        end else begin
                            r_dwell <= r_dwell + 26'd1;
                        end
                    end else begin
                        r_dwell <= '0;
                    end
                end
                c_ST_CALC: begin
                    r_best     <= w_best_nxt;
                    r_best_idx <= w_bidx_nxt;
                    r_tie_acc  <= w_tie_nxt;
                    r_idx      <= r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        disp_n       <= w_best_nxt;
                        disp_sel     <= w_bidx_nxt;
                        led          <= onehot(w_bidx_nxt);
                        tie          <= w_tie_nxt;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        r_state      <= c_ST_RESULT;
                    end
                end
                c_ST_RESULT: begin
                    if (w_next_edge) begin
                        disp_sel     <= 2'd0;
                        led          <= 4'b0001;
                        r_dwell      <= '0;
                        result_valid <= 1'b0;
                        tie          <= 1'b0;
                        r_state      <= c_ST_SCAN;
                    end
                end
                default: begin
                    r_state <= c_ST_SCAN;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_scheduler
//  Description : Self-checking bench for display_scheduler with DWELL=4.
//                Vector tables for auto-rotate and manual stepping, plus
//                directed sequences for winner, tie, coincident events and
//                reset during the comparison.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] cnt0, cnt1, cnt2, cnt3;
    logic       next_btn, auto_en, result_req;
    logic [6:0] disp_n;
    logic [1:0] disp_sel;
    logic [3:0] led;
    logic       busy, result_valid, tie;

    int n_checks = 0;
    int n_errors = 0;

    display_scheduler #(.DWELL(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cnt0         (cnt0),
        .cnt1         (cnt1),
        .cnt2         (cnt2),
        .cnt3         (cnt3),
        .next_btn     (next_btn),
        .auto_en      (auto_en),
        .result_req   (result_req),
        .disp_n       (disp_n),
        .disp_sel     (disp_sel),
        .led          (led),
        .busy         (busy),
        .result_valid (result_valid),
        .tie          (tie)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       nb;
        logic       ae;
        logic       rr;
        logic [6:0] c0, c1, c2, c3;
        logic [6:0] e_dn;
        logic [1:0] e_sel;
        logic       e_busy;
        logic       e_rv;
        logic       e_tie;
    } vec_t;

    vec_t vecs[$];

    // Auto-rotate, cnt={5,10,15,20}: state after each edge following reset.
    logic [6:0] a_dn  [17] = '{5,5,5,5,10,10,10,10,15,15,15,15,20,20,20,20,5};
    logic [1:0] a_sel [17] = '{0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0,0};
    // Manual stepping; entry 0 is a reset with the button held high.
    logic       b_nb  [12] = '{1,1,0,1,0,1,0,1,1,0,1,0};
    logic [6:0] b_dn  [12] = '{0,5,5,5,10,10,15,15,20,20,20,5};
    logic [1:0] b_sel [12] = '{0,0,0,1,1,2,2,3,3,3,0,0};

    function automatic vec_t mk(input logic r, input logic nb, input logic ae,
                                input logic rr, input logic [6:0] dn,
                                input logic [1:0] sel);
        vec_t v;
        v.rst = r;  v.nb = nb; v.ae = ae; v.rr = rr;
        v.c0 = 7'd5; v.c1 = 7'd10; v.c2 = 7'd15; v.c3 = 7'd20;
        v.e_dn = dn; v.e_sel = sel;
        v.e_busy = 1'b0; v.e_rv = 1'b0; v.e_tie = 1'b0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [6:0] dn, input logic [1:0] sel,
                           input logic b, input logic rv, input logic t);
        logic [3:0] exp_led;
        exp_led = 4'b0001 << sel;
        chk({tag, "/disp_n"},       32'(disp_n),       32'(dn));
        chk({tag, "/disp_sel"},     32'(disp_sel),     32'(sel));
        chk({tag, "/led"},          32'(led),          32'(exp_led));
        chk({tag, "/busy"},         32'(busy),         32'(b));
        chk({tag, "/result_valid"}, 32'(result_valid), 32'(rv));
        chk({tag, "/tie"},          32'(tie),          32'(t));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cnt(input logic [6:0] a, input logic [6:0] b,
                           input logic [6:0] c, input logic [6:0] d);
        cnt0 = a; cnt1 = b; cnt2 = c; cnt3 = d;
    endtask

    initial begin
        rst = 1'b1; next_btn = 1'b0; auto_en = 1'b0; result_req = 1'b0;
        set_cnt(0, 0, 0, 0);

        // ---------------- table-driven vectors ----------------
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 7'd0, 2'd0));
        for (int i = 0; i < 17; i++)
            vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, a_dn[i], a_sel[i]));
        for (int i = 0; i < 12; i++)
            vecs.push_back(mk(i == 0, b_nb[i], 1'b0, 1'b0, b_dn[i], b_sel[i]));

        foreach (vecs[i]) begin
            rst = vecs[i].rst; next_btn = vecs[i].nb;
            auto_en = vecs[i].ae; result_req = vecs[i].rr;
            set_cnt(vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].c3);
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].e_dn, vecs[i].e_sel,
                    vecs[i].e_busy, vecs[i].e_rv, vecs[i].e_tie);
        end

        // ---------------- unique winner ----------------
        rst = 1'b1; next_btn = 1'b0; auto_en = 1'b0; result_req = 1'b0;
        set_cnt(12, 47, 30, 9);
        step();
        rst = 1'b0;
        step();
        chk_out("win_idle", 12, 0, 0, 0, 0);
        result_req = 1'b1;
        step();
        chk_out("win_k", 12, 0, 1, 0, 0);
        step();
        chk_out("win_k1", 12, 0, 1, 0, 0);
        step();
        chk_out("win_k2", 12, 0, 1, 0, 0);
        step();
        chk_out("win_k3", 47, 1, 0, 1, 0);
        cnt1 = 7'd80; result_req = 1'b0;
        step();
        result_req = 1'b1;
        step();
        chk_out("win_frozen", 47, 1, 0, 1, 0);
        next_btn = 1'b1;
        step();
        chk_out("win_exit", 47, 0, 0, 0, 0);
        next_btn = 1'b0;
        step();
        chk_out("win_scan", 12, 0, 0, 0, 0);

        // ---------------- tie ----------------
        set_cnt(33, 20, 33, 33);
        result_req = 1'b0;
        step();
        result_req = 1'b1;
        step();
        chk_out("tie_k", 33, 0, 1, 0, 0);
        step(); step(); step();
        chk_out("tie_res", 33, 0, 0, 1, 1);
        next_btn = 1'b1;
        step();
        chk_out("tie_exit", 33, 0, 0, 0, 0);
        next_btn = 1'b0;

        // ---------------- early tie cleared by larger later count ----------------
        set_cnt(5, 5, 9, 1);
        result_req = 1'b0;
        step();
        result_req = 1'b1;
        step(); step(); step(); step();
        chk_out("tieclr_res", 9, 2, 0, 1, 0);
        next_btn = 1'b1;
        step();
        next_btn = 1'b0;
        result_req = 1'b0;

        // ---------------- coincident events ----------------
        rst = 1'b1; auto_en = 1'b1;
        set_cnt(5, 10, 15, 20);
        step();
        rst = 1'b0;
        step(); step(); step();
        chk_out("sim_pre", 5, 0, 0, 0, 0);
        next_btn = 1'b1;            // lands on dwell expiry
        step();
        chk_out("sim_expiry", 5, 1, 0, 0, 0);
        next_btn = 1'b0;
        step();
        chk_out("sim_after", 10, 1, 0, 0, 0);
        next_btn = 1'b1; result_req = 1'b1;
        step();
        chk_out("sim_both", 10, 1, 1, 0, 0);
        next_btn = 1'b0; result_req = 1'b0;
        step(); step(); step();
        chk_out("sim_res", 20, 3, 0, 1, 0);
        next_btn = 1'b1;
        step();
        next_btn = 1'b0; auto_en = 1'b0;

        // ---------------- reset during CALC ----------------
        step();
        result_req = 1'b1;
        step();
        chk_out("rstc_k", 5, 0, 1, 0, 0);
        rst = 1'b1;
        step();
        chk_out("rstc_k1", 0, 0, 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("rstc_post%0d/result_valid", i), 32'(result_valid), 32'd0);
            chk($sformatf("rstc_post%0d/busy", i), 32'(busy), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
